div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for signed/unsigned
// division and remainder, with single-cycle handling of divide-by-zero
// and signed overflow.
module div_unit #(
  parameter int unsigned DWidth   = 32,
  parameter int unsigned CntWidth = $clog2(DWidth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWidth-1:0] a_i,
  input  logic [DWidth-1:0] b_i,
  input  logic [1:0]        op_sel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWidth-1:0] res_o,
  output logic              zero_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [DWidth-1:0] MinNeg = {1'b1, {(DWidth-1){1'b0}}};

  state_t              state, state_next;
  logic [CntWidth-1:0] cnt;
  logic [DWidth-1:0]   rem, quo, dvs, res;
  logic                sel_rem, q_neg, r_neg;

  // Operand decode at the accept boundary.
  logic              is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
  logic [DWidth-1:0] a_mag, b_mag, spec_res;

  assign is_signed = ~op_sel_i[0];
  assign a_neg     = is_signed & a_i[DWidth-1];
  assign b_neg     = is_signed & b_i[DWidth-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign div_zero  = (b_i == '0);
  assign ovf       = is_signed && (a_i == MinNeg) && (b_i == '1);
  assign special   = div_zero | ovf;
  assign accept    = in_valid_i && (state == IDLE);

  // Special-case result: divide-by-zero takes precedence over overflow.
  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = op_sel_i[1] ? a_i : '1;
    else          spec_res = op_sel_i[1] ? '0  : MinNeg;
  end

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  logic [DWidth:0]   r_sh, diff;
  logic [DWidth-1:0] rem_step, quo_step;

  always_comb begin
    r_sh     = {rem, quo[DWidth-1]};
    diff     = r_sh - {1'b0, dvs};
    rem_step = r_sh[DWidth-1:0];
    quo_step = {quo[DWidth-2:0], 1'b0};
    if (!diff[DWidth]) begin
      rem_step = diff[DWidth-1:0];
      quo_step = {quo[DWidth-2:0], 1'b1};
    end
  end

  // Sign fix-up and result selection.
  logic [DWidth-1:0] q_fin, r_fin;
  assign q_fin = q_neg ? -quo : quo;
  assign r_fin = r_neg ? -rem : rem;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next  = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_next = special ? DONE : CALC;
      end
      CALC: if (cnt == CntWidth'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      res     <= '0;
      sel_rem <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sel_rem <= op_sel_i[1];
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          rem     <= '0;
          quo     <= a_mag;
          dvs     <= b_mag;
          if (special) begin
            res <= spec_res;
            cnt <= '0;
          end else begin
            cnt <= CntWidth'(DWidth);
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - CntWidth'(1);
        end
        FIX:     res <= sel_rem ? r_fin : q_fin;
        default: ;
      endcase
    end
  end

  assign res_o  = res;
  assign zero_o = (res == '0);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (DWidth = 32).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_i, b_i;
  logic [1:0]  op_sel_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] res_o;
  logic        zero_o;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit #(.DWidth(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_sel_i    (op_sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .zero_o      (zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, check result, hold DONE for
  // 'hold' cycles, then release while in_valid is high (must not accept).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    op_sel_i   = op;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    a_i        = $urandom;
    b_i        = $urandom;
    op_sel_i   = 2'($urandom);
    chk({tag, "_ready_busy"}, 32'(in_ready_o), 32'd0);
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, res_o, exp);
    chk({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, "_hold_res"}, res_o, exp);
      chk({tag, "_hold_ready"}, 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    a_i         = 32'd1;
    b_i         = 32'd1;
    op_sel_i    = OP_DIVU;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk({tag, "_release_ready"}, 32'(in_ready_o), 32'd1);
    chk({tag, "_release_valid"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = 32'hDEAD_BEEF;
    b_i         = 32'h1234_5678;
    op_sel_i    = OP_DIV;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    rst_ni = 1'b1;

    do_op("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 10);
    do_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0);
    do_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0);
    do_op("divu_5_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
    do_op("remu_5_0",    OP_REMU, 32'd5,          32'd0,          32'd5,          1,  0);
    do_op("div_m7_0",    OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1,  0);
    do_op("rem_m7_0",    OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  2);
    do_op("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
    do_op("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
    do_op("divu_big_m1", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 0);
    do_op("div_min_2",   OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34, 0);
    do_op("div_100_m7",  OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34, 0);
    do_op("rem_100_m7",  OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          34, 0);
    do_op("div_m100_m7", OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34, 0);
    do_op("rem_m100_m7", OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34, 0);
    do_op("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 0);
    do_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         34, 0);
    do_op("rem_exact",   OP_REM,  32'd21,         32'd7,          32'd0,          34, 0);

    // Reset during CALC abandons the operation.
    @(negedge clk);
    in_valid_i = 1'b1;
    a_i        = 32'd1000;
    b_i        = 32'd10;
    op_sel_i   = OP_DIVU;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    chk("midrst_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_res", res_o, 32'd0);
    chk("midrst_zero", 32'(zero_o), 32'd1);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_o) seen_valid = 1;
    end
    chk("midrst_no_result", 32'(seen_valid), 32'd0);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
